// File: rtl/accu_alu_bank.sv
// Bank of num_acc accumulators with per-accumulator carry sharing one ALU.
// Commands use a valid/ready handshake; MUL runs as a data_width-cycle shift-add.
module accu_alu_bank #(
   parameter int data_width    = 8,
   parameter int op_code_width = 4,
   parameter int num_acc       = 4,
   localparam int sel_width    = (num_acc > 1) ? $clog2(num_acc) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [op_code_width-1:0] opcode,
   input  logic [sel_width-1:0]     acc_sel,
   input  logic [data_width-1:0]    data_in,
   input  logic [sel_width-1:0]     rd_sel,
   output logic [data_width-1:0]    data_out,
   output logic                     cy,
   output logic                     zero,
   output logic                     done,
   output logic                     illegal
);

   localparam int cnt_width = $clog2(data_width);
   localparam logic [cnt_width-1:0] cnt_last = cnt_width'(data_width - 1);

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_LOAD = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_XOR  = 4'd6;
   localparam logic [3:0] OP_NOT  = 4'd7;
   localparam logic [3:0] OP_SHL  = 4'd8;
   localparam logic [3:0] OP_SHR  = 4'd9;
   localparam logic [3:0] OP_ADC  = 4'd10;
   localparam logic [3:0] OP_CLRC = 4'd11;
   localparam logic [3:0] OP_MUL  = 4'd12;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t                    state;
   logic [data_width-1:0]     acc [num_acc];
   logic [num_acc-1:0]        cy_reg;
   logic [2*data_width-1:0]   mcand;
   logic [2*data_width-1:0]   prod;
   logic [2*data_width-1:0]   prod_next;
   logic [data_width-1:0]     mplier;
   logic [sel_width-1:0]      mul_sel;
   logic [cnt_width-1:0]      cnt;

   logic [data_width-1:0]     op_a;
   logic                      op_c;
   logic [data_width-1:0]     res_a;
   logic                      res_c;
   logic [data_width:0]       ext;
   logic                      op_illegal;
   logic                      op_mul;

   assign in_ready  = (state == S_IDLE);
   assign data_out  = acc[rd_sel];
   assign cy        = cy_reg[rd_sel];
   assign zero      = (data_out == '0);
   assign prod_next = prod + (mplier[0] ? mcand : '0);

   // Single-cycle ALU result for the addressed accumulator; ext holds carry/borrow in its top bit.
   always_comb begin
      op_a       = acc[acc_sel];
      op_c       = cy_reg[acc_sel];
      res_a      = op_a;
      res_c      = op_c;
      ext        = '0;
      op_illegal = 1'b0;
      op_mul     = 1'b0;
      if (|(opcode >> 4)) begin
         op_illegal = 1'b1;
      end else begin
         case (opcode[3:0])
            OP_NOP:  ;
            OP_LOAD: res_a = data_in;
            OP_ADD: begin
               ext           = {1'b0, op_a} + {1'b0, data_in};
               {res_c, res_a} = ext;
            end
            OP_SUB: begin
               ext           = {1'b0, op_a} - {1'b0, data_in};
               {res_c, res_a} = ext;
            end
            OP_AND:  res_a = op_a & data_in;
            OP_OR:   res_a = op_a | data_in;
            OP_XOR:  res_a = op_a ^ data_in;
            OP_NOT:  res_a = ~op_a;
            OP_SHL:  {res_c, res_a} = {op_a, 1'b0};
            OP_SHR:  {res_a, res_c} = {1'b0, op_a};
            OP_ADC: begin
               ext           = {1'b0, op_a} + {1'b0, data_in} + {{data_width{1'b0}}, op_c};
               {res_c, res_a} = ext;
            end
            OP_CLRC: res_c = 1'b0;
            OP_MUL:  op_mul = 1'b1;
            default: op_illegal = 1'b1;
         endcase
      end
   end

   // Command FSM: single-cycle ops commit straight from IDLE; MUL consumes one multiplier bit per cycle
   // and commits on its last cycle using prod_next so the latency is exactly data_width edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         done    <= 1'b0;
         illegal <= 1'b0;
         cy_reg  <= '0;
         mcand   <= '0;
         prod    <= '0;
         mplier  <= '0;
         mul_sel <= '0;
         cnt     <= '0;
         for (int i = 0; i < num_acc; i++) begin
            acc[i] <= '0;
         end
      end else begin
         done    <= 1'b0;
         illegal <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  if (op_mul) begin
                     state   <= S_MUL;
                     mcand   <= {{data_width{1'b0}}, op_a};
                     mplier  <= data_in;
                     mul_sel <= acc_sel;
                     prod    <= '0;
                     cnt     <= '0;
                  end else begin
                     done    <= 1'b1;
                     illegal <= op_illegal;
                     if (!op_illegal) begin
                        acc[acc_sel]    <= res_a;
                        cy_reg[acc_sel] <= res_c;
                     end
                  end
               end
            end
            S_MUL: begin
               prod   <= prod_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               if (cnt == cnt_last) begin
                  acc[mul_sel]    <= prod_next[data_width-1:0];
                  cy_reg[mul_sel] <= |prod_next[2*data_width-1:data_width];
                  done            <= 1'b1;
                  state           <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_accu_alu_bank.sv
// Directed bench for accu_alu_bank (data_width=8, num_acc=4) with hand-computed expectations.
`timescale 1ns/100ps
module tb_accu_alu_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] opcode;
   logic [1:0] acc_sel;
   logic [7:0] data_in;
   logic [1:0] rd_sel;
   logic [7:0] data_out;
   logic       cy;
   logic       zero;
   logic       done;
   logic       illegal;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] d;
   logic       c, z, gd, gi;

   accu_alu_bank #(.data_width(8), .op_code_width(4), .num_acc(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
      .acc_sel(acc_sel), .data_in(data_in), .rd_sel(rd_sel), .data_out(data_out),
      .cy(cy), .zero(zero), .done(done), .illegal(illegal)
   );

   always #10 clk = ~clk;

   task automatic issue(input logic [3:0] op, input logic [1:0] sel, input logic [7:0] din,
                        output logic o_done, output logic o_ill);
      @(negedge clk);
      in_valid = 1'b1; opcode = op; acc_sel = sel; data_in = din;
      @(posedge clk); #1;
      o_done = done; o_ill = illegal;
      in_valid = 1'b0;
   endtask

   task automatic rd(input logic [1:0] s, output logic [7:0] o_d, output logic o_c, output logic o_z);
      rd_sel = s; #1;
      o_d = data_out; o_c = cy; o_z = zero;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; opcode = '0; acc_sel = '0; data_in = '0; rd_sel = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      issue(4'd1, 2'd1, 8'h77, gd, gi);
      @(posedge clk); #3; rst = 1'b1; #1;
      for (int s = 0; s < 4; s++) begin
         rd(2'(s), d, c, z);
         n_vec++;
         if ({d, c, z} !== {8'h00, 1'b0, 1'b1}) begin
            n_err++; $display("[TB] FAIL reset_acc%0d got %h/%b/%b want 00/0/1", s, d, c, z);
         end
      end
      n_vec++;
      if ({in_ready, done, illegal} !== 3'b100) begin
         n_err++; $display("[TB] FAIL reset_ctrl got %b want 100", {in_ready, done, illegal});
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_add_adc;
      issue(4'd1, 2'd1, 8'hF0, gd, gi);
      n_vec++;
      if ({gd, gi} !== 2'b10) begin n_err++; $display("[TB] FAIL load_done got %b want 10", {gd, gi}); end
      issue(4'd2, 2'd1, 8'h20, gd, gi);
      n_vec++;
      if ({gd, gi} !== 2'b10) begin n_err++; $display("[TB] FAIL add_done got %b want 10", {gd, gi}); end
      rd(2'd1, d, c, z);
      n_vec++;
      if ({d, c, z} !== {8'h10, 1'b1, 1'b0}) begin
         n_err++; $display("[TB] FAIL add_acc1 got %h/%b/%b want 10/1/0", d, c, z);
      end
      for (int s = 0; s < 4; s += 1) begin
         if (s == 1) continue;
         rd(2'(s), d, c, z);
         n_vec++;
         if ({d, c} !== {8'h00, 1'b0}) begin
            n_err++; $display("[TB] FAIL others_acc%0d got %h/%b want 00/0", s, d, c);
         end
      end
      issue(4'd10, 2'd1, 8'h00, gd, gi);
      rd(2'd1, d, c, z);
      n_vec++;
      if ({gd, d, c} !== {1'b1, 8'h11, 1'b0}) begin
         n_err++; $display("[TB] FAIL adc_acc1 got %b/%h/%b want 1/11/0", gd, d, c);
      end
   endtask

   task automatic test_sub_shift;
      issue(4'd1, 2'd2, 8'h05, gd, gi);
      issue(4'd3, 2'd2, 8'h06, gd, gi);
      rd(2'd2, d, c, z);
      n_vec++;
      if ({d, c, z} !== {8'hFF, 1'b1, 1'b0}) begin
         n_err++; $display("[TB] FAIL sub_borrow got %h/%b/%b want ff/1/0", d, c, z);
      end
      issue(4'd9, 2'd2, 8'h00, gd, gi);
      rd(2'd2, d, c, z);
      n_vec++;
      if ({d, c} !== {8'h7F, 1'b1}) begin
         n_err++; $display("[TB] FAIL shr got %h/%b want 7f/1", d, c);
      end
      issue(4'd1, 2'd2, 8'h80, gd, gi);
      issue(4'd8, 2'd2, 8'h00, gd, gi);
      rd(2'd2, d, c, z);
      n_vec++;
      if ({d, c, z} !== {8'h00, 1'b1, 1'b1}) begin
         n_err++; $display("[TB] FAIL shl got %h/%b/%b want 00/1/1", d, c, z);
      end
   endtask

   task automatic test_mul;
      issue(4'd1, 2'd3, 8'h12, gd, gi);
      @(negedge clk);
      in_valid = 1'b1; opcode = 4'd12; acc_sel = 2'd3; data_in = 8'h34;
      @(posedge clk); #1;
      n_vec++;
      if ({in_ready, done} !== 2'b00) begin
         n_err++; $display("[TB] FAIL mul_accept got %b want 00", {in_ready, done});
      end
      opcode = 4'd1; data_in = 8'hEE;
      for (int k = 1; k < 8; k++) begin
         @(posedge clk); #1;
         rd(2'd3, d, c, z);
         n_vec++;
         if ({in_ready, done, d} !== {2'b00, 8'h12}) begin
            n_err++; $display("[TB] FAIL mul_busy%0d got %b/%h want 00/12", k, {in_ready, done}, d);
         end
      end
      @(posedge clk); #1;
      n_vec++;
      if ({done, illegal, in_ready} !== 3'b101) begin
         n_err++; $display("[TB] FAIL mul_done got %b want 101", {done, illegal, in_ready});
      end
      in_valid = 1'b0;
      rd(2'd3, d, c, z);
      n_vec++;
      if ({d, c, z} !== {8'hA8, 1'b1, 1'b0}) begin
         n_err++; $display("[TB] FAIL mul_result got %h/%b/%b want a8/1/0", d, c, z);
      end
      @(posedge clk); #1;
      rd(2'd3, d, c, z);
      n_vec++;
      if ({done, d} !== {1'b0, 8'hA8}) begin
         n_err++; $display("[TB] FAIL mul_hold got %b/%h want 0/a8", done, d);
      end
   endtask

   task automatic test_reset_mid_mul;
      logic seen_done;
      issue(4'd12, 2'd3, 8'h34, gd, gi);
      repeat (3) @(posedge clk);
      #3; rst = 1'b1; #2; rst = 1'b0; #1;
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL abort_ready got %b want 1", in_ready); end
      seen_done = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done !== 1'b0) seen_done = 1'b1;
      end
      n_vec++;
      if (seen_done !== 1'b0) begin n_err++; $display("[TB] FAIL abort_no_done got %b want 0", seen_done); end
      rd(2'd3, d, c, z);
      n_vec++;
      if ({d, c, z} !== {8'h00, 1'b0, 1'b1}) begin
         n_err++; $display("[TB] FAIL abort_acc3 got %h/%b/%b want 00/0/1", d, c, z);
      end
      issue(4'd1, 2'd3, 8'h5A, gd, gi);
      rd(2'd3, d, c, z);
      n_vec++;
      if ({gd, d} !== {1'b1, 8'h5A}) begin
         n_err++; $display("[TB] FAIL abort_reload got %b/%h want 1/5a", gd, d);
      end
   endtask

   task automatic test_illegal;
      issue(4'd1, 2'd0, 8'hFF, gd, gi);
      issue(4'd2, 2'd0, 8'h01, gd, gi);
      issue(4'd1, 2'd0, 8'h55, gd, gi);
      issue(4'd13, 2'd0, 8'hAA, gd, gi);
      n_vec++;
      if ({gd, gi} !== 2'b11) begin n_err++; $display("[TB] FAIL illegal13_flags got %b want 11", {gd, gi}); end
      rd(2'd0, d, c, z);
      n_vec++;
      if ({d, c} !== {8'h55, 1'b1}) begin
         n_err++; $display("[TB] FAIL illegal13_state got %h/%b want 55/1", d, c);
      end
      issue(4'd15, 2'd0, 8'h00, gd, gi);
      rd(2'd0, d, c, z);
      n_vec++;
      if ({gd, gi, d} !== {2'b11, 8'h55}) begin
         n_err++; $display("[TB] FAIL illegal15 got %b/%h want 11/55", {gd, gi}, d);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({done, illegal} !== 2'b00) begin
         n_err++; $display("[TB] FAIL illegal_pulse got %b want 00", {done, illegal});
      end
   endtask

   task automatic test_logic;
      logic [3:0] ops  [6] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd11, 4'd0};
      logic [7:0] dins [6] = '{8'h0F, 8'hF0, 8'hFF, 8'h00, 8'h00, 8'h00};
      logic [7:0] exp_d[6] = '{8'h05, 8'hF5, 8'h0A, 8'hF5, 8'hF5, 8'hF5};
      logic       exp_c[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         issue(ops[i], 2'd0, dins[i], gd, gi);
         rd(2'd0, d, c, z);
         n_vec++;
         if ({gd, gi, d, c} !== {2'b10, exp_d[i], exp_c[i]}) begin
            n_err++; $display("[TB] FAIL logic_op%0d got %b/%h/%b want 10/%h/%b", ops[i], {gd, gi}, d, c, exp_d[i], exp_c[i]);
         end
      end
   endtask

   initial begin
      test_reset;
      test_add_adc;
      test_sub_shift;
      test_mul;
      test_reset_mid_mul;
      test_illegal;
      test_logic;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
